// File: rtl/axi_protocol_monitor.sv
// rtl/axi_protocol_monitor.sv - passive AXI link checker with transaction tracking and error reporting
module axi_protocol_monitor #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADD_WIDTH       = 8,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 256
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 awvalid,
    input  logic                                 awready,
    input  logic [ADD_WIDTH-1:0]                 awaddr,
    input  logic [7:0]                           awlen,
    input  logic [2:0]                           awsize,
    input  logic [ID_WIDTH-1:0]                  awid,
    input  logic                                 wvalid,
    input  logic                                 wready,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic [DATA_WIDTH/8-1:0]              wstrb,
    input  logic                                 wlast,
    input  logic [ID_WIDTH-1:0]                  wid,
    input  logic                                 bvalid,
    input  logic                                 bready,
    input  logic                                 arvalid,
    input  logic                                 arready,
    input  logic [ADD_WIDTH-1:0]                 araddr,
    input  logic [7:0]                           arlen,
    input  logic [2:0]                           arsize,
    input  logic [ID_WIDTH-1:0]                  arid,
    input  logic                                 rvalid,
    input  logic                                 rready,
    input  logic                                 rlast,
    input  logic                                 err_clr,
    output logic [9:0]                           err_pulse,
    output logic [9:0]                           err_sticky,
    output logic [15:0]                          err_count,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding
);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int AWP = ADD_WIDTH + 8 + 3 + ID_WIDTH;
    localparam int WP  = DATA_WIDTH + DATA_WIDTH/8 + 1 + ID_WIDTH;
    localparam logic [CW-1:0] OUT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_MAX = PW'(MAX_OUTSTANDING - 1);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LIM   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    logic [AWP-1:0] aw_pl, ar_pl, aw_copy, ar_copy;
    logic [WP-1:0]  w_pl, w_copy;
    logic           aw_stall_q, ar_stall_q, w_stall_q;
    assign aw_pl = {awaddr, awlen, awsize, awid};
    assign ar_pl = {araddr, arlen, arsize, arid};
    assign w_pl  = {wdata, wstrb, wlast, wid};

    logic          rst_seen;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    len_mem [MAX_OUTSTANDING];
    logic [7:0]    beat;
    logic [7:0]    b_pend;
    logic [TW-1:0] stall_cnt [5];
    logic [4:0]    stall;
    assign stall = {rvalid & ~rready, arvalid & ~arready, bvalid & ~bready,
                    wvalid & ~wready, awvalid & ~awready};

    logic       fifo_empty, fifo_full, rd_full, w_ok, push, pop;
    logic [7:0] cur_len;
    logic [4:0] tmo_hit;
    logic [9:0] viol;

    always_comb begin
        fifo_empty = (fifo_cnt == '0);
        fifo_full  = (fifo_cnt == OUT_MAX);
        rd_full    = (rd_outstanding == OUT_MAX);
        // An AW accepted alongside the first beat supplies the length directly.
        cur_len    = fifo_empty ? awlen : len_mem[rd_ptr];
        w_ok       = w_hs & (~fifo_empty | aw_hs);
        push       = aw_hs & ~fifo_full;
        pop        = w_ok & wlast;
        for (int i = 0; i < 5; i++)
            tmo_hit[i] = (TIMEOUT > 0) && stall[i] && (stall_cnt[i] == T_LIM);
        viol    = '0;
        viol[0] = aw_stall_q & (~awvalid | (aw_pl != aw_copy));
        viol[1] = ar_stall_q & (~arvalid | (ar_pl != ar_copy));
        viol[2] = w_stall_q  & (~wvalid  | (w_pl  != w_copy));
        viol[3] = rst_seen;
        viol[4] = rvalid & (rd_outstanding == '0);
        viol[5] = bvalid & (b_pend == '0);
        viol[6] = w_ok & (wlast != (beat == cur_len));
        viol[7] = w_hs & fifo_empty & ~aw_hs;
        viol[8] = |tmo_hit;
        viol[9] = (ar_hs & rd_full) | (aw_hs & fifo_full);
    end

    // Deliberately not reset: remembers valids seen while areset is held.
    always_ff @(posedge aclk) begin
        if (areset) begin
            if (awvalid | wvalid | arvalid | rvalid | bvalid)
                rst_seen <= 1'b1;
        end else begin
            rst_seen <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            len_mem[wr_ptr] <= awlen;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_pulse      <= '0;
            err_sticky     <= '0;
            err_count      <= '0;
            rd_outstanding <= '0;
            fifo_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            beat           <= '0;
            b_pend         <= '0;
            aw_stall_q     <= 1'b0;
            ar_stall_q     <= 1'b0;
            w_stall_q      <= 1'b0;
            aw_copy        <= '0;
            ar_copy        <= '0;
            w_copy         <= '0;
            for (int i = 0; i < 5; i++)
                stall_cnt[i] <= '0;
        end else begin
            err_pulse <= viol;
            if (err_clr) begin
                err_sticky <= viol;
                err_count  <= {15'd0, |viol};
            end else begin
                err_sticky <= err_sticky | viol;
                if ((|viol) && err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end

            aw_stall_q <= awvalid & ~awready;
            ar_stall_q <= arvalid & ~arready;
            w_stall_q  <= wvalid & ~wready;
            aw_copy    <= aw_pl;
            ar_copy    <= ar_pl;
            w_copy     <= w_pl;

            if ((ar_hs && !rd_full) && !(r_hs && rlast && rd_outstanding != '0))
                rd_outstanding <= rd_outstanding + 1'b1;
            else if (!(ar_hs && !rd_full) && (r_hs && rlast && rd_outstanding != '0))
                rd_outstanding <= rd_outstanding - 1'b1;

            if (push)
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - 1'b1;

            if (pop)
                beat <= '0;
            else if (w_ok)
                beat <= beat + 8'd1;

            if (pop && !(b_hs && b_pend != '0)) begin
                if (b_pend != 8'hFF)
                    b_pend <= b_pend + 8'd1;
            end else if (!pop && b_hs && b_pend != '0) begin
                b_pend <= b_pend - 8'd1;
            end

            for (int i = 0; i < 5; i++) begin
                if (!stall[i])
                    stall_cnt[i] <= '0;
                else if (stall_cnt[i] != T_MAX)
                    stall_cnt[i] <= stall_cnt[i] + 1'b1;
            end
        end
    end

    assign wr_outstanding = fifo_cnt;
endmodule

// File: tb/tb_axi_protocol_monitor.sv
// tb/tb_axi_protocol_monitor.sv - directed-vector bench for axi_protocol_monitor
module tb_axi_protocol_monitor;
    logic        aclk = 1'b0;
    logic        areset;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast, err_clr;
    logic [7:0]  awaddr, awlen, awid, wid, araddr, arlen, arid;
    logic [2:0]  awsize, arsize;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic [9:0]  err_pulse, err_sticky;
    logic [15:0] err_count;
    logic [2:0]  rd_outstanding, wr_outstanding;
    int          vectors = 0;
    int          miscompares = 0;
    int          hits, hit_at, others;

    always #5 aclk = ~aclk;

    axi_protocol_monitor #(
        .DATA_WIDTH(16), .ADD_WIDTH(8), .ID_WIDTH(8), .MAX_OUTSTANDING(4), .TIMEOUT(8)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wid(wid),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .err_clr(err_clr), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_count(err_count), .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_hs(input logic [7:0] len);
        awvalid = 1'b1; awready = 1'b1; awlen = len;
        tick();
        awvalid = 1'b0; awready = 1'b0;
    endtask

    task automatic w_beat(input logic last);
        wvalid = 1'b1; wready = 1'b1; wlast = last;
        tick();
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_hs();
        bvalid = 1'b1; bready = 1'b1;
        tick();
        bvalid = 1'b0; bready = 1'b0;
    endtask

    task automatic ar_hs();
        arvalid = 1'b1; arready = 1'b1;
        tick();
        arvalid = 1'b0; arready = 1'b0;
    endtask

    task automatic r_hs(input logic last);
        rvalid = 1'b1; rready = 1'b1; rlast = last;
        tick();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        {awvalid, awready, wvalid, wready, wlast, bvalid, bready} = '0;
        {arvalid, arready, rvalid, rready, rlast, err_clr} = '0;
        {awaddr, awlen, awid, wid, araddr, arlen, arid} = '0;
        {awsize, arsize, wdata, wstrb} = '0;
        areset = 1'b1;
        tick(); tick();
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_sticky", 32'(err_sticky), 0);
        check("rst_count", 32'(err_count), 0);
        check("rst_rd_out", 32'(rd_outstanding), 0);
        check("rst_wr_out", 32'(wr_outstanding), 0);
        areset = 1'b0;
        tick();

        // AW payload changes while stalled
        awvalid = 1'b1; awready = 1'b0; awaddr = 8'h10;
        tick();
        awaddr = 8'h11;
        tick();
        check("aw_stable_pulse", 32'(err_pulse), 32'h001);
        tick();
        check("aw_stable_once", 32'(err_pulse), 0);
        check("aw_stable_sticky", 32'(err_sticky), 32'h001);
        check("aw_stable_count", 32'(err_count), 1);
        awready = 1'b1;
        tick();
        awvalid = 1'b0; awready = 1'b0;
        check("aw_drain_wr_out", 32'(wr_outstanding), 1);
        w_beat(1'b1);
        check("aw_drain_wr_out0", 32'(wr_outstanding), 0);
        b_hs();
        check("aw_drain_count", 32'(err_count), 1);
        clear_errors();
        check("clr_sticky", 32'(err_sticky), 0);
        check("clr_count", 32'(err_count), 0);

        // clean 4-beat write
        aw_hs(8'd3);
        check("clean_wr_out1", 32'(wr_outstanding), 1);
        w_beat(1'b0); w_beat(1'b0); w_beat(1'b0);
        check("clean_mid_wr_out", 32'(wr_outstanding), 1);
        w_beat(1'b1);
        check("clean_wr_out0", 32'(wr_outstanding), 0);
        b_hs();
        check("clean_sticky", 32'(err_sticky), 0);
        check("clean_count", 32'(err_count), 0);

        // early wlast on the second beat
        aw_hs(8'd3);
        w_beat(1'b0);
        w_beat(1'b1);
        check("early_pulse", 32'(err_pulse), 32'h040);
        check("early_wr_out", 32'(wr_outstanding), 0);
        b_hs();
        check("early_b_ok", 32'(err_pulse), 0);
        check("early_sticky", 32'(err_sticky), 32'h040);
        clear_errors();

        // read overflow then orphan R
        for (int i = 0; i < 4; i++) ar_hs();
        check("rd_fill_out", 32'(rd_outstanding), 4);
        check("rd_fill_pulse", 32'(err_pulse), 0);
        ar_hs();
        check("rd_ovf_pulse", 32'(err_pulse), 32'h200);
        check("rd_ovf_out", 32'(rd_outstanding), 4);
        for (int i = 0; i < 4; i++) r_hs(1'b1);
        check("rd_drain_out", 32'(rd_outstanding), 0);
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        check("r_unexp_pulse", 32'(err_pulse), 32'h010);

        // W beat with no AW queued
        w_beat(1'b1);
        check("w_no_aw_pulse", 32'(err_pulse), 32'h080);
        check("w_no_aw_wr_out", 32'(wr_outstanding), 0);
        check("accum_sticky", 32'(err_sticky), 32'h290);
        check("accum_count", 32'(err_count), 3);
        clear_errors();

        // AR stall timeout
        hits = 0; hit_at = 0; others = 0;
        arvalid = 1'b1; arready = 1'b0; araddr = 8'h44;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (err_pulse[8]) begin hits++; hit_at = i; end
            if ((err_pulse & 10'h2FF) != 0) others++;
        end
        check("tmo_hits", 32'(hits), 1);
        check("tmo_at", 32'(hit_at), 8);
        check("tmo_others", 32'(others), 0);
        arready = 1'b1;
        tick();
        arvalid = 1'b0; arready = 1'b0;
        check("tmo_rd_out", 32'(rd_outstanding), 1);
        r_hs(1'b1);
        check("tmo_count", 32'(err_count), 1);

        // reset mid-burst with wvalid held
        aw_hs(8'd3);
        w_beat(1'b0);
        wvalid = 1'b1; wready = 1'b0; areset = 1'b1;
        tick(); tick();
        check("inrst_pulse", 32'(err_pulse), 0);
        wvalid = 1'b0; areset = 1'b0;
        tick();
        check("rst_valid_pulse", 32'(err_pulse), 32'h008);
        check("rst_valid_sticky", 32'(err_sticky), 32'h008);
        check("rst_valid_count", 32'(err_count), 1);
        check("rst_wr_out_cleared", 32'(wr_outstanding), 0);
        err_clr = 1'b1; bvalid = 1'b1; bready = 1'b1;
        tick();
        err_clr = 1'b0; bvalid = 1'b0; bready = 1'b0;
        check("clr_win_pulse", 32'(err_pulse), 32'h020);
        check("clr_win_sticky", 32'(err_sticky), 32'h020);
        check("clr_win_count", 32'(err_count), 1);
        aw_hs(8'd0);
        w_beat(1'b1);
        check("post_rst_beat", 32'(err_pulse), 0);
        b_hs();
        check("post_rst_b", 32'(err_pulse), 0);
        check("final_sticky", 32'(err_sticky), 32'h020);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_protocol_monitor.md
# axi_protocol_monitor

Synthesizable, parametrised AXI protocol monitor that sits passively on one master/slave link alongside the VIP interface. It checks handshake stability, reset quiescence, response ordering, burst length, outstanding-depth and stall-timeout rules. Violations are reported as registered per-rule pulses, sticky flags and a saturating error count, so the same checker runs in simulation, emulation and FPGA bring-up. Unlike the simulation-only property checker, it tracks transaction state: outstanding reads, queued write bursts, beat counts and stall timers.

## Interface
- DATA_WIDTH, 16, data bus width; multiple of 8
- ADD_WIDTH, 8, address width
- ID_WIDTH, 8, transaction ID width
- MAX_OUTSTANDING, 4, write-length FIFO depth and outstanding-read limit; ≥1
- TIMEOUT, 256, stall cycles before a timeout is flagged; 0 disables the check
- aclk  in  1  single clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- awvalid, awready, awaddr, awlen, awsize, awid  in  1/1/ADD_WIDTH/8/3/ID_WIDTH  write-address channel
- wvalid, wready, wdata, wstrb, wlast, wid  in  1/1/DATA_WIDTH/DATA_WIDTH/8/1/ID_WIDTH  write-data channel
- bvalid, bready  in  1/1  write-response channel
- arvalid, arready, araddr, arlen, arsize, arid  in  1/1/ADD_WIDTH/8/3/ID_WIDTH  read-address channel
- rvalid, rready, rlast  in  1/1/1  read-data channel
- err_clr  in  1  clears err_sticky and err_count
- err_pulse  out  10  one-cycle flag per rule violated
- err_sticky  out  10  accumulated violations
- err_count  out  16  saturating count of cycles with any violation
- rd_outstanding, wr_outstanding  out  clog2(MAX_OUTSTANDING+1)  accepted-but-incomplete reads; queued write bursts

## Operation
- Error bits:
  - 0 AW_STABLE, 1 AR_STABLE, 2 W_STABLE
  - 3 RST_VALID, 4 R_UNEXPECTED, 5 B_UNEXPECTED
  - 6 WLAST_MISMATCH, 7 W_NO_AW
  - 8 TIMEOUT, 9 OVERFLOW
- Handshake: valid & ready at a rising edge.
- Stability (bits 0–2): if valid=1 and ready=0 at edge N-1, then at edge N valid must be 1 and the payload must equal the registered copy. AW payload: awaddr/awlen/awsize/awid. AR payload: araddr/arlen/arsize/arid. W payload: wdata/wstrb/wlast/wid.
- RST_VALID: any of aw/w/ar/r/bvalid high at an edge with areset=1. This is captured in a reset-immune latch and raised in the first cycle after reset release.
- Read tracking: rd_outstanding +1 on an AR handshake and -1 on an R handshake with rlast=1; both in the same cycle gives net 0.
  - rvalid=1 while rd_outstanding=0 sets R_UNEXPECTED; the counter never goes below 0.
  - An AR handshake at rd_outstanding=MAX_OUTSTANDING sets OVERFLOW, and the count is not incremented.
- Write tracking: FIFO of awlen, depth MAX_OUTSTANDING. An AW handshake pushes; pushing into a full FIFO sets OVERFLOW and the entry is dropped.
  - The beat counter (8 bits) increments on each W handshake.
  - Burst length comes from the FIFO head. If the FIFO is empty and AW handshakes in the same cycle, awlen is bypassed.
  - A W handshake with an empty FIFO and no AW handshake sets W_NO_AW; the beat is ignored.
  - WLAST_MISMATCH: wlast=1 with beat≠len, or wlast=0 with beat==len.
  - wlast=1 always pops the FIFO and zeroes the beat counter, mismatch or not.
- B tracking: pending count +1 on a wlast handshake, -1 on a B handshake. bvalid=1 with pending=0 sets B_UNEXPECTED.
- Timeout: one stall counter per channel (AW, W, B, AR, R). It increments while valid & !ready and clears otherwise.
  - TIMEOUT is raised once per stall episode, when a counter reaches TIMEOUT; the counter saturates.
- err_count increments by 1 per cycle in which err_pulse≠0 and saturates at 0xFFFF.
- err_clr zeroes err_sticky and err_count. A violation in the same cycle wins: its sticky bit sets and the count becomes 1.

## Timing
- Reset values:
  - err_pulse, err_sticky, err_count: 0.
  - rd_outstanding, wr_outstanding: 0; FIFO empty; beat, pending and stall counters 0.
  - The RST_VALID latch is not cleared by areset.
- A violation sampled at edge N drives err_pulse high for the cycle after edge N and sets err_sticky at the same edge.
- Counter outputs reflect handshakes at edge N from edge N onward (registered, 1-cycle latency).
- Reset mid-burst discards all tracking state. No error is raised for the aborted transactions.

## Test plan
- Write stall: awvalid=1, awready=0, awaddr 0x10 → 0x11 on the next edge → err_pulse[0]=1 for one cycle; err_sticky[0] stays 1; err_count=1.
- Clean write: awlen=3 handshake, 4 W beats with wlast on the 4th, then B handshake → no errors; wr_outstanding goes 1→0.
- Early wlast: awlen=3, wlast on beat 2 → WLAST_MISMATCH; FIFO empty afterwards; a following bvalid is accepted without error.
- Read overflow and orphan response (MAX_OUTSTANDING=4): 5 AR handshakes with no R → OVERFLOW on the 5th, rd_outstanding=4. Then 4 R handshakes with rlast, and rvalid on the next cycle → R_UNEXPECTED.
- Stall timeout (TIMEOUT=8): arvalid=1, arready=0 for 20 cycles → exactly one TIMEOUT pulse, 8 cycles after the stall begins.
- Reset and clear: wvalid=1 during areset → RST_VALID in the first cycle after release. Then assert err_clr together with a new B_UNEXPECTED → only err_sticky[5] set; err_count=1.
